// File: rtl/fpu_pkg.sv
// Shared types and constants for the double-precision rounding/packing stages.
package fpu_pkg;

  localparam int EXP_W   = 11;
  localparam int FRAC_W  = 52;
  localparam int EXP_MAX = 2047;
  localparam int STAGES  = 3;

  typedef enum logic [1:0] {
    RNE = 2'b00,  // nearest, ties to even
    RTZ = 2'b01,  // toward zero
    RUP = 2'b10,  // toward +inf
    RDN = 2'b11   // toward -inf
  } rmode_e;

  localparam logic [EXP_W-1:0]  EXP_INF     = '1;
  localparam logic [EXP_W-1:0]  EXP_MAXFIN  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0] FRAC_ZERO   = '0;
  localparam logic [FRAC_W-1:0] FRAC_MAXFIN = '1;
  localparam logic [EXP_W:0]    EXP_MAX12   = (EXP_W+1)'(EXP_MAX);

  // Stage 1 -> 2: captured operand plus the rounding decision.
  typedef struct packed {
    logic              sign;
    logic [FRAC_W:0]   m53;
    logic [EXP_W-1:0]  exp;
    rmode_e            rmode;
    logic              inc;
    logic              inexact_p;
    logic              special;
  } s1_t;

  // Stage 2 -> 3: rounded fraction with a widened exponent so overflow is visible.
  typedef struct packed {
    logic              sign;
    logic [FRAC_W-1:0] frac;
    logic [EXP_W:0]    exp12;
    rmode_e            rmode;
    logic              inexact_p;
    logic              special;
  } s2_t;

endpackage

// File: rtl/fpu_round_decide.sv
// Round-up decision from mode, sign, result lsb, guard and sticky.
// Purely combinational so the mul/div rounders can share it.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  rmode_e i_rmode,
  input  logic   i_sign,
  input  logic   i_lsb,
  input  logic   i_g,
  input  logic   i_s,
  output logic   o_inc
);

  // Select the increment rule for the active rounding mode.
  always_comb begin
    o_inc = 1'b0;
    unique case (i_rmode)
      RNE: o_inc = i_g & (i_s | i_lsb);
      RTZ: o_inc = 1'b0;
      RUP: o_inc = ~i_sign & (i_g | i_s);
      RDN: o_inc =  i_sign & (i_g | i_s);
      default: o_inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_add_round.sv
// Post-add rounding and packing: 3-stage pipeline (decide, increment, pack),
// every stage frozen while enable is low.
module fpu_add_round
  import fpu_pkg::*;
#(
  parameter int EXP_W  = fpu_pkg::EXP_W,
  parameter int FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [1:0]              rmode,
  input  logic                    sign,
  input  logic [FRAC_W+3:0]       sum_2,
  input  logic [EXP_W-1:0]        exponent_2,
  output logic [EXP_W+FRAC_W:0]   out,
  output logic                    out_valid,
  output logic                    overflow,
  output logic                    inexact
);

  logic [STAGES:1]          r_vld_pipe;
  s1_t                      r_s1, w_s1;
  s2_t                      r_s2, w_s2;
  logic [EXP_W+FRAC_W:0]    r_out, w_out;
  logic                     r_ovf, w_ovf;
  logic                     r_inx, w_inx;
  logic                     w_inc;
  logic [FRAC_W+1:0]        w_mr;
  logic                     w_to_inf;
  logic                     w_unused_msb;

  // sum_2[55] is always zero from the adder; it carries no information here.
  assign w_unused_msb = sum_2[FRAC_W+3];

  fpu_round_decide u_decide (
    .i_rmode (rmode_e'(rmode)),
    .i_sign  (sign),
    .i_lsb   (sum_2[2]),
    .i_g     (sum_2[1]),
    .i_s     (sum_2[0]),
    .o_inc   (w_inc)
  );

  // Stage 1: split the sum into mantissa/guard/sticky and decide rounding.
  always_comb begin
    w_s1           = '0;
    w_s1.sign      = sign;
    w_s1.m53       = sum_2[FRAC_W+2:2];
    w_s1.exp       = exponent_2;
    w_s1.rmode     = rmode_e'(rmode);
    w_s1.inc       = w_inc;
    w_s1.inexact_p = sum_2[1] | sum_2[0];
    w_s1.special   = (exponent_2 == EXP_INF);
  end

  // Stage 2: apply the increment, then fix up carry-out and denormal promotion.
  assign w_mr = {1'b0, r_s1.m53} + {{(FRAC_W+1){1'b0}}, r_s1.inc};

  always_comb begin
    w_s2           = '0;
    w_s2.sign      = r_s1.sign;
    w_s2.rmode     = r_s1.rmode;
    w_s2.inexact_p = r_s1.inexact_p;
    w_s2.special   = r_s1.special;
    w_s2.frac      = w_mr[FRAC_W-1:0];
    w_s2.exp12     = {1'b0, r_s1.exp};
    if (r_s1.special) begin
      // inf/NaN: keep the payload untouched, never round
      w_s2.frac  = r_s1.m53[FRAC_W-1:0];
      w_s2.exp12 = EXP_MAX12;
    end else if (w_mr[FRAC_W+1]) begin
      w_s2.frac  = w_mr[FRAC_W:1];
      w_s2.exp12 = {1'b0, r_s1.exp} + 1'b1;
    end else if (r_s1.exp == '0 && w_mr[FRAC_W]) begin
      // denormal rounded into the hidden bit becomes the smallest normal
      w_s2.exp12 = {{EXP_W{1'b0}}, 1'b1};
    end
  end

  // Stage 3: pack, saturating to inf or max-finite when the exponent overflows.
  assign w_to_inf = (r_s2.rmode == RNE) ||
                    (r_s2.rmode == RUP && !r_s2.sign) ||
                    (r_s2.rmode == RDN &&  r_s2.sign);

  always_comb begin
    w_ovf = 1'b0;
    w_inx = r_s2.inexact_p & ~r_s2.special;
    w_out = {r_s2.sign, r_s2.exp12[EXP_W-1:0], r_s2.frac};
    if (!r_s2.special && r_s2.exp12 >= EXP_MAX12) begin
      w_ovf = 1'b1;
      w_inx = 1'b1;
      w_out = w_to_inf ? {r_s2.sign, EXP_INF, FRAC_ZERO}
                       : {r_s2.sign, EXP_MAXFIN, FRAC_MAXFIN};
    end
  end

  // Pipeline registers; reset wins over enable and drops all in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_out      <= '0;
      r_ovf      <= 1'b0;
      r_inx      <= 1'b0;
    end else if (enable) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r_s1       <= w_s1;
      r_s2       <= w_s2;
      r_out      <= w_out;
      r_ovf      <= w_ovf;
      r_inx      <= w_inx;
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld_pipe[STAGES];
  assign overflow  = r_ovf;
  assign inexact   = r_inx;

endmodule

// File: tb/tb_fpu_add_round.sv
// Scoreboard bench for fpu_add_round: expectations queued at input capture,
// compared when an enabled edge produces out_valid.
module tb_fpu_add_round;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, sign;
  logic [1:0]  rmode;
  logic [55:0] sum_2;
  logic [10:0] exponent_2;
  logic [63:0] out;
  logic        out_valid, overflow, inexact;

  typedef struct {
    logic [63:0] out;
    logic        ovf;
    logic        inx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   en_edge;

  fpu_add_round dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .rmode      (rmode),
    .sign       (sign),
    .sum_2      (sum_2),
    .exponent_2 (exponent_2),
    .out        (out),
    .out_valid  (out_valid),
    .overflow   (overflow),
    .inexact    (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference rounding of one operand, written from the IEEE rules.
  function automatic exp_t model(input logic s, input logic [55:0] sm,
                                 input logic [10:0] ein, input logic [1:0] rm);
    exp_t        r;
    logic [53:0] m;
    logic [11:0] e;
    logic        up, g, st, l;
    g = sm[1]; st = sm[0]; l = sm[2];
    case (rm)
      2'd0:    up = g & (st | l);
      2'd1:    up = 1'b0;
      2'd2:    up = !s & (g | st);
      default: up = s & (g | st);
    endcase
    r.ovf = 1'b0;
    r.inx = g | st;
    if (ein == 11'd2047) begin
      r.out = {s, 11'h7FF, sm[53:2]};
      r.inx = 1'b0;
    end else begin
      m = {1'b0, sm[54:2]} + 54'(up);
      e = {1'b0, ein};
      if (m[53]) begin
        m = m >> 1;
        e = e + 12'd1;
      end else if (e == 12'd0 && m[52]) begin
        e = 12'd1;
      end
      if (e >= 12'd2047) begin
        r.ovf = 1'b1;
        r.inx = 1'b1;
        if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s))
          r.out = {s, 11'h7FF, 52'h0};
        else
          r.out = {s, 11'h7FE, 52'hF_FFFF_FFFF_FFFF};
      end else begin
        r.out = {s, e[10:0], m[51:0]};
      end
    end
    return r;
  endfunction

  // Output monitor: only an enabled edge can produce a new result.
  always @(posedge clk) begin
    en_edge = enable & ~rst;
    #1;
    if (en_edge && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out", out, mon_e.out);
        chk("overflow", 64'(overflow), 64'(mon_e.ovf));
        chk("inexact", 64'(inexact), 64'(mon_e.inx));
      end
    end
  end

  task automatic drive(input logic s, input logic [55:0] sm, input logic [10:0] e,
                       input logic [1:0] rm, input logic vld, input logic en);
    @(negedge clk);
    sign = s; sum_2 = sm; exponent_2 = e; rmode = rm;
    in_valid = vld; enable = en;
  endtask

  task automatic push_vec(input logic s, input logic [55:0] sm, input logic [10:0] e,
                          input logic [1:0] rm, input logic [63:0] xo,
                          input logic xovf, input logic xinx);
    exp_t t;
    drive(s, sm, e, rm, 1'b1, 1'b1);
    t.out = xo; t.ovf = xovf; t.inx = xinx;
    sb.push_back(t);
  endtask

  task automatic push_model(input logic s, input logic [55:0] sm, input logic [10:0] e,
                            input logic [1:0] rm);
    drive(s, sm, e, rm, 1'b1, 1'b1);
    sb.push_back(model(s, sm, e, rm));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      enable   = 1'b1;
    end
  endtask

  localparam logic [55:0] ALL1 = 56'h7F_FFFF_FFFF_FFFF;

  initial begin
    logic [55:0] rs;
    logic [10:0] re;
    int          k;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; sign = 1'b0;
    rmode = 2'd0; sum_2 = '0; exponent_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_inx", 64'(inexact), 64'd0);
    rst = 1'b0;

    // Directed cases
    push_vec(0, 56'h40000000000000, 11'd1023, 2'd0, 64'h3FF0000000000000, 0, 0);
    push_vec(0, 56'h40000000000002, 11'd1023, 2'd0, 64'h3FF0000000000000, 0, 1);
    push_vec(0, 56'h40000000000006, 11'd1023, 2'd0, 64'h3FF0000000000002, 0, 1);
    push_vec(0, ALL1,               11'd1023, 2'd0, 64'h4000000000000000, 0, 1);
    push_vec(0, ALL1,               11'd1023, 2'd1, 64'h3FFFFFFFFFFFFFFF, 0, 1);
    push_vec(0, ALL1,               11'd2046, 2'd0, 64'h7FF0000000000000, 1, 1);
    push_vec(0, ALL1,               11'd2046, 2'd1, 64'h7FEFFFFFFFFFFFFF, 0, 1);
    push_vec(1, ALL1,               11'd2046, 2'd2, 64'hFFEFFFFFFFFFFFFF, 0, 1);
    push_vec(1, ALL1,               11'd2046, 2'd3, 64'hFFF0000000000000, 1, 1);
    push_vec(0, ALL1,               11'd2046, 2'd3, 64'h7FEFFFFFFFFFFFFF, 0, 1);
    push_vec(0, 56'h3FFFFFFFFFFFFE, 11'd0,    2'd0, 64'h0010000000000000, 0, 1);
    push_vec(1, 56'h0,              11'd0,    2'd0, 64'h8000000000000000, 0, 0);
    push_vec(0, 56'h00000000000001, 11'd0,    2'd2, 64'h0000000000000001, 0, 1);
    push_vec(0, 56'h40000000000007, 11'd2047, 2'd2, 64'h7FF0000000000001, 0, 0);
    push_vec(1, 56'h40000000000001, 11'd1023, 2'd3, 64'hBFF0000000000001, 0, 1);
    idle(5);

    // Latency counted in enabled edges, with stalls interleaved
    push_vec(0, 56'h40000000000000, 11'd1024, 2'd0, 64'h4000000000000000, 0, 0);
    @(negedge clk); chk("lat_e1", 64'(out_valid), 64'd0); in_valid = 1'b0; enable = 1'b0;
    @(negedge clk); chk("lat_stall1", 64'(out_valid), 64'd0); enable = 1'b1;
    @(negedge clk); chk("lat_e2", 64'(out_valid), 64'd0); enable = 1'b0;
    @(negedge clk); chk("lat_stall2", 64'(out_valid), 64'd0); enable = 1'b1;
    @(negedge clk); chk("lat_e3", 64'(out_valid), 64'd1);
    idle(4);

    // Back-to-back valids with enable 1,0,1,1,1; the stalled vector is re-presented
    push_vec(0, 56'h40000000000000, 11'd1000, 2'd0, 64'h3E80000000000000, 0, 0);
    drive(1, 56'h40000000000006, 11'd1001, 2'd1, 1'b1, 1'b0);
    push_vec(1, 56'h40000000000006, 11'd1001, 2'd1, 64'hBE90000000000001, 0, 1);
    push_vec(0, ALL1,               11'd1002, 2'd2, 64'h3EB0000000000000, 0, 1);
    push_vec(1, ALL1,               11'd1003, 2'd2, 64'hBEBFFFFFFFFFFFFF, 0, 1);
    idle(5);

    // Reset with one operand in flight: nothing may come out
    push_vec(0, 56'h40000000000000, 11'd1023, 2'd0, 64'h3FF0000000000000, 0, 0);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; sb.delete();
    repeat (2) @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", out, 64'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_valid", 64'(out_valid), 64'd0);
    end

    // Random traffic with random stalls and bubbles
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       re = 11'd0;
        1:       re = 11'd2046;
        2:       re = 11'd2047;
        3:       re = 11'd1;
        default: re = 11'($urandom_range(1, 2046));
      endcase
      rs = {$urandom, $urandom};
      rs[55] = 1'b0;
      rs[54] = (re != 11'd0);
      if ($urandom_range(0, 4) == 0)
        drive(1'($urandom), rs, re, 2'($urandom), 1'($urandom), 1'b0);
      else if ($urandom_range(0, 3) == 0)
        drive(1'($urandom), rs, re, 2'($urandom), 1'b0, 1'b1);
      else
        push_model(1'($urandom), rs, re, 2'($urandom));
    end

    // Drain with a bounded wait
    idle(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("drain_pending", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_add_round.md
Name: fpu_add_round

Overview:
- Post-add rounding and packing stage. Sits directly downstream of the adder alignment/sum stage.
- Consumes the unrounded sign, 56-bit sum and biased exponent. Applies IEEE-754 double rounding (4 modes).
- Handles mantissa carry-out, denormal-to-normal promotion and exponent overflow.
- Emits a packed 64-bit double plus overflow/inexact flags through a fixed 3-stage pipeline gated by enable.

Parameters:
EXP_W, 11, exponent width (only default verified)
FRAC_W, 52, stored fraction width (only default verified)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
enable  input  1  pipeline advance; low freezes every stage
in_valid  input  1  sign/sum_2/exponent_2 valid this cycle
rmode  input  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
sign  input  1  result sign
sum_2  input  56  [55]=0, [54]=hidden bit, [53:2]=fraction, [1]=guard, [0]=sticky
exponent_2  input  11  biased exponent; 0 = denormal/zero, 2047 = inf/NaN
out  output  64  packed double {sign, exp[10:0], frac[51:0]}
out_valid  output  1  out/flags valid
overflow  output  1  rounding produced exponent >= 2047
inexact  output  1  guard|sticky was nonzero

Behaviour:
- Reset: clk and reset rst, synchronous, active-high. All pipeline registers clear. out=0, out_valid=0, overflow=0, inexact=0.
- Reset mid-operation discards all in-flight data. No output appears for inputs taken before reset.
- enable=0: no register changes, including the valid chain. Latency is 3 enabled cycles from input capture to out_valid.
- in_valid=0 bubbles propagate as out_valid=0. Data registers may still load; benches check out only when out_valid=1.
- Stage 1 (capture/decide):
  - Register sign, m53 = sum_2[54:2], g = sum_2[1], s = sum_2[0], exponent_2, rmode.
  - Compute inc:
    - RNE: g & (s | m53[0])
    - RTZ: 0
    - RUP: !sign & (g|s)
    - RDN: sign & (g|s)
  - Register inexact_p = g|s and special = (exponent_2 == 2047).
- Stage 2 (increment):
  - mr[53:0] = {1'b0, m53} + inc. Exponent held as 12 bits.
  - mr[53]=1: fraction = mr[52:1], exp = exp+1.
  - Else if exp==0 and mr[52]=1: exp = 1 (denormal rounds up to min normal), fraction = mr[51:0].
  - Else: fraction = mr[51:0], exp unchanged.
  - special=1: inc ignored; fraction = m53[51:0], exp = 2047 (inf/NaN payload preserved).
- Stage 3 (pack/exceptions):
  - If !special and exp12 >= 2047: overflow=1.
    - RNE, or RUP with sign=0, or RDN with sign=1: out = {sign, 11'h7FF, 52'b0}.
    - Otherwise: out = {sign, 11'h7FE, 52'hF_FFFF_FFFF_FFFF} (max finite).
    - inexact=1 on overflow.
  - Else: out = {sign, exp[10:0], fraction}, overflow=0, inexact = inexact_p & !special.
- Zero in (exp 0, sum 0) gives signed zero. Sign always passes through unchanged.

Decomposition:
- Package fpu_pkg holds:
  - rounding-mode enum: RNE, RTZ, RUP, RDN
  - EXP_W, FRAC_W, EXP_MAX=2047
  - constants for +inf and max-finite exponent/fraction patterns
- One natural sub-module: fpu_round_decide. Combinational; inputs (rmode, sign, lsb, g, s), outputs inc. Reused by the mul/div rounders.

Test Plan:
- sum_2=56'h40000000000000, exp 1023, RNE, valid -> 3 enabled cycles later out=64'h3FF0000000000000, inexact=0, overflow=0.
- sum_2=56'h40000000000002 (tie, lsb 0), exp 1023, RNE -> 64'h3FF0000000000000, inexact=1. Same with sum_2=56'h40000000000006 -> 64'h3FF0000000000002.
- sum_2=56'h7FFFFFFFFFFFFF, exp 1023, RNE -> carry-out, 64'h4000000000000000. Same input with RTZ -> 64'h3FFFFFFFFFFFFFFF, inexact=1.
- sum_2=56'h7FFFFFFFFFFFFF, exp 2046, sign 0:
  - RNE -> 64'h7FF0000000000000, overflow=1.
  - RTZ -> 64'h7FEFFFFFFFFFFFFF, overflow=0, inexact=1.
  - sign 1 with RUP -> 64'hFFEFFFFFFFFFFFFF.
- exp 0, sum_2=56'h3FFFFFFFFFFFFE, RNE -> denormal promotes, out=64'h0010000000000000.
- Back-to-back valids with enable toggling 1,0,1,1,1 -> outputs in order, out_valid only after 3 enabled edges. Assert rst after 1 input -> out_valid stays 0, out=0.
